// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and sequencer in front of a single-port data memory.
// One transaction in flight at a time; out-of-range addresses are answered with err and never reach memory.
//
// state | meaning
// IDLE  | sample requests, pick winner, latch request, drive gnt/mem command next cycle
// ISSUE | gnt and memory command visible; writes/errors respond next, reads start latency count
// WAIT  | count down read latency, capture mem_rdata when counter reaches 1
// RESP  | winner's rvalid visible; rr pointer moves to the other port
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 21,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_en,
  output logic              mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0]  LAT     = 3'(READ_LAT);
  localparam logic [32:0] DEPTH_U = 33'(DEPTH);

  state_t            state, state_d;
  logic              win, win_d;
  logic              we_l, we_d;
  logic [ADDR_W-1:0] addr_l, addr_d;
  logic [DATA_W-1:0] wdata_l, wdata_d;
  logic              err_l, err_d;
  logic              rr, rr_d;
  logic [2:0]        cnt, cnt_d;

  logic [1:0]        gnt_d, rvalid_d;
  logic [DATA_W-1:0] rdata_d;
  logic              err_o_d;
  logic              mem_en_d, mem_cmd_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  logic              sel, sel_we, sel_legal;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A lone requester always wins; the rr pointer only breaks ties.
  assign sel       = (p0_req && p1_req) ? rr : p1_req;
  assign sel_we    = sel ? p1_we    : p0_we;
  assign sel_addr  = sel ? p1_addr  : p0_addr;
  assign sel_wdata = sel ? p1_wdata : p0_wdata;
  assign sel_legal = 33'(sel_addr) < DEPTH_U;

  always_comb begin
    state_d     = state;
    win_d       = win;
    we_d        = we_l;
    addr_d      = addr_l;
    wdata_d     = wdata_l;
    err_d       = err_l;
    rr_d        = rr;
    cnt_d       = cnt;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = '0;
    err_o_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_cmd_d   = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          win_d      = sel;
          we_d       = sel_we;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          err_d      = !sel_legal;
          gnt_d[sel] = 1'b1;
          if (sel_legal) begin
            mem_en_d    = 1'b1;
            mem_cmd_d   = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_l || err_l) begin
          rvalid_d[win] = 1'b1;
          err_o_d       = err_l;
          state_d       = RESP;
        end else begin
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - 3'd1;
        if (cnt == 3'd1) begin
          rvalid_d[win] = 1'b1;
          rdata_d       = mem_rdata;
          state_d       = RESP;
        end
      end
      RESP: begin
        rr_d    = !win;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      win       <= 1'b0;
      we_l      <= 1'b0;
      addr_l    <= '0;
      wdata_l   <= '0;
      err_l     <= 1'b0;
      rr        <= 1'b0;
      cnt       <= '0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_cmd   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      win       <= win_d;
      we_l      <= we_d;
      addr_l    <= addr_d;
      wdata_l   <= wdata_d;
      err_l     <= err_d;
      rr        <= rr_d;
      cnt       <= cnt_d;
      p0_gnt    <= gnt_d[0];
      p1_gnt    <= gnt_d[1];
      p0_rvalid <= rvalid_d[0];
      p1_rvalid <= rvalid_d[1];
      p0_rdata  <= rvalid_d[0] ? rdata_d : '0;
      p1_rdata  <= rvalid_d[1] ? rdata_d : '0;
      p0_err    <= rvalid_d[0] & err_o_d;
      p1_err    <= rvalid_d[1] & err_o_d;
      mem_en    <= mem_en_d;
      mem_cmd   <= mem_cmd_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule
